// File: rtl/logger_uart_tx_if.sv
// Logger FIFO read port plus UART line and status outputs of the serial back end.
// master = the UART transmitter, slave = the FIFO / status side.
interface logger_uart_tx_if #(
  parameter int CNT_W = 32
);
  logic             fifo_rd_en;
  logic [7:0]       fifo_dout;
  logic             fifo_empty;
  logic             uart_txd;
  logic             tx_busy;
  logic             byte_done;
  logic [CNT_W-1:0] byte_cnt;
  logic [CNT_W-1:0] line_cnt;

  modport master (
    output fifo_rd_en,
    input  fifo_dout,
    input  fifo_empty,
    output uart_txd,
    output tx_busy,
    output byte_done,
    output byte_cnt,
    output line_cnt
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_dout,
    output fifo_empty,
    input  uart_txd,
    input  tx_busy,
    input  byte_done,
    input  byte_cnt,
    input  line_cnt
  );
endinterface

// File: rtl/logger_uart_tx.sv
// Drains the logger FIFO one byte per frame onto an 8N1 UART line (LSB first) and counts bytes/lines.
// Latency: txd falls 2 cycles after the read strobe; the FIFO is only read from IDLE, one read per frame.
module logger_uart_tx #(
  parameter int CLK_HZ = 125_000_000,
  parameter int BAUD   = 115_200,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  logger_uart_tx_if.master bus
);

  localparam int CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_cpb_check
      $error("logger_uart_tx: CLKS_PER_BIT must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [7:0]         r_shift;
  logic [7:0]         r_copy;
  logic [BAUD_W-1:0]  r_baud;
  logic [2:0]         r_bit_idx;
  logic               r_txd;
  logic [CNT_W-1:0]   r_byte_cnt;
  logic [CNT_W-1:0]   r_line_cnt;

  logic               w_bit_end;
  logic               w_rd_en;
  logic               w_byte_done;
  logic               w_txd_d;

  assign w_bit_end = (r_baud == BAUD_LAST);

  always_comb begin
    w_next      = r_state;
    w_rd_en     = 1'b0;
    w_byte_done = 1'b0;
    case (r_state)
      IDLE: begin
        w_rd_en = ~bus.fifo_empty;
        if (!bus.fifo_empty) w_next = LOAD;
      end
      LOAD:  w_next = START;
      START: if (w_bit_end) w_next = DATA;
      DATA:  if (w_bit_end && (r_bit_idx == 3'd7)) w_next = STOP;
      STOP: begin
        if (w_bit_end) begin
          w_byte_done = 1'b1;
          w_next      = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Line level for the next cycle, so uart_txd comes straight from a flop.
  always_comb begin
    w_txd_d = 1'b1;
    case (w_next)
      START:   w_txd_d = 1'b0;
      DATA:    w_txd_d = (r_state == DATA && w_bit_end) ? r_shift[1] : r_shift[0];
      default: w_txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_txd      <= 1'b1;
      r_shift    <= 8'h00;
      r_copy     <= 8'h00;
      r_baud     <= '0;
      r_bit_idx  <= 3'd0;
      r_byte_cnt <= '0;
      r_line_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_txd   <= w_txd_d;
      case (r_state)
        LOAD: begin
          r_shift   <= bus.fifo_dout;
          r_copy    <= bus.fifo_dout;
          r_baud    <= '0;
          r_bit_idx <= 3'd0;
        end
        START: r_baud <= w_bit_end ? '0 : r_baud + 1'b1;
        DATA: begin
          r_baud <= w_bit_end ? '0 : r_baud + 1'b1;
          if (w_bit_end) begin
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
          end
        end
        STOP: begin
          r_baud <= w_bit_end ? '0 : r_baud + 1'b1;
          if (w_bit_end) begin
            r_byte_cnt <= r_byte_cnt + CNT_W'(1);
            if (r_copy == 8'h0A) r_line_cnt <= r_line_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.uart_txd   = r_txd;
  assign bus.tx_busy    = (r_state != IDLE);
  assign bus.byte_done  = w_byte_done;
  assign bus.byte_cnt   = r_byte_cnt;
  assign bus.line_cnt   = r_line_cnt;

endmodule

// File: tb/tb_logger_uart_tx.sv
// Bench for logger_uart_tx: FIFO model, frame-timing scoreboard, mid-bit UART decoder and scenario tasks.
// A CNT_W=4 copy runs on the same FIFO inputs to exercise counter wrap.
module tb_logger_uart_tx;
  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int CPB    = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int PITCH  = 10 * CPB + 2;

  typedef logic [7:0] byte_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;
  logic rst_q;
  bit   mon_en;

  byte_t fq[$];
  byte_t exp_q[$];
  byte_t rx_q[$];
  int    rd_cycles[$];
  int    done_cycles[$];

  bit          sb_active;
  int          sb_start;
  byte_t       sb_byte;
  logic [31:0] exp_bc;
  logic [31:0] exp_lc;

  logger_uart_tx_if #(.CNT_W(32)) bus0 ();
  logger_uart_tx_if #(.CNT_W(4))  bus1 ();

  logger_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .CNT_W(32)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  logger_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .CNT_W(4))  dut1 (.clk(clk), .rst(rst), .bus(bus1));

  assign bus1.fifo_dout  = bus0.fifo_dout;
  assign bus1.fifo_empty = bus0.fifo_empty;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc   = 0;
    rst_q = 1'b1;
    forever begin
      @(posedge clk);
      cyc++;
      rst_q = rst;
    end
  end

  // Standard (non-FWFT) FIFO: data appears the cycle after the read strobe, empty flag is registered.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        fq.delete();
        bus0.fifo_empty <= 1'b1;
        bus0.fifo_dout  <= 8'h00;
      end else begin
        if (bus0.fifo_rd_en === 1'b1 && fq.size() > 0) bus0.fifo_dout <= fq.pop_front();
        bus0.fifo_empty <= (fq.size() == 0);
      end
    end
  end

  // Scoreboard: each read at cycle c yields start bit at c+2, bits at CPB pitch, byte_done at c+1+10*CPB.
  initial begin
    logic e_txd, e_busy, e_done;
    int   off, j;
    sb_active = 0; sb_start = 0; sb_byte = 8'h00; exp_bc = 0; exp_lc = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (rst_q) begin
          checks++;
          if (bus0.uart_txd !== 1'b1 || bus0.tx_busy !== 1'b0 || bus0.byte_done !== 1'b0 ||
              bus0.byte_cnt !== 32'd0 || bus0.line_cnt !== 32'd0 || bus1.uart_txd !== 1'b1 || bus1.byte_cnt !== 4'd0) begin
            errors++;
            $display("FAIL sb_reset cyc=%0d: txd=%b busy=%b done=%b bc=%0d lc=%0d, required 1 0 0 0 0",
                     cyc, bus0.uart_txd, bus0.tx_busy, bus0.byte_done, bus0.byte_cnt, bus0.line_cnt);
          end
          sb_active = 0; exp_bc = 0; exp_lc = 0;
          exp_q.delete();
        end else begin
          e_txd = 1'b1; e_busy = 1'b0; e_done = 1'b0;
          if (sb_active) begin
            off    = cyc - sb_start;
            e_busy = (off >= 1);
            if (off >= 2) begin
              j = (off - 2) / CPB;
              e_txd = (j == 0) ? 1'b0 : (j <= 8) ? sb_byte[j-1] : 1'b1;
            end
            e_done = (off == 1 + 10 * CPB);
          end
          checks++;
          if (bus0.uart_txd !== e_txd) begin errors++; $display("FAIL sb_txd cyc=%0d: got %b required %b", cyc, bus0.uart_txd, e_txd); end
          checks++;
          if (bus0.tx_busy !== e_busy) begin errors++; $display("FAIL sb_busy cyc=%0d: got %b required %b", cyc, bus0.tx_busy, e_busy); end
          checks++;
          if (bus0.byte_done !== e_done) begin errors++; $display("FAIL sb_done cyc=%0d: got %b required %b", cyc, bus0.byte_done, e_done); end
          checks++;
          if (bus0.byte_cnt !== exp_bc || bus0.line_cnt !== exp_lc) begin
            errors++; $display("FAIL sb_counts cyc=%0d: got %0d/%0d required %0d/%0d", cyc, bus0.byte_cnt, bus0.line_cnt, exp_bc, exp_lc);
          end
          checks++;
          if ({bus1.uart_txd, bus1.tx_busy, bus1.byte_done, bus1.fifo_rd_en} !== {e_txd, e_busy, e_done, bus0.fifo_rd_en} ||
              bus1.byte_cnt !== exp_bc[3:0] || bus1.line_cnt !== exp_lc[3:0]) begin
            errors++; $display("FAIL sb_dut4 cyc=%0d: txd=%b bc=%0d lc=%0d required txd=%b bc=%0d lc=%0d",
                               cyc, bus1.uart_txd, bus1.byte_cnt, bus1.line_cnt, e_txd, exp_bc[3:0], exp_lc[3:0]);
          end
          if (bus0.fifo_rd_en === 1'b1) begin
            checks++;
            if (bus0.fifo_empty !== 1'b0 || sb_active) begin
              errors++; $display("FAIL sb_rd_illegal cyc=%0d: empty=%b in_frame=%0d, required 0 0", cyc, bus0.fifo_empty, sb_active);
            end
            rd_cycles.push_back(cyc);
            sb_byte   = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
            sb_active = 1;
            sb_start  = cyc;
          end else if (!sb_active && bus0.fifo_empty === 1'b0) begin
            checks++; errors++;
            $display("FAIL sb_rd_missing cyc=%0d: got rd_en=%b required 1", cyc, bus0.fifo_rd_en);
          end
          if (e_done) begin
            exp_bc = exp_bc + 1;
            if (sb_byte == 8'h0A) exp_lc = exp_lc + 1;
            sb_active = 0;
            done_cycles.push_back(cyc);
          end
        end
      end
    end
  end

  // Independent receiver: sample each bit in its middle after a falling edge.
  initial begin
    logic  prev;
    byte_t rb;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && !rst_q && prev === 1'b1 && bus0.uart_txd === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          rb[k] = bus0.uart_txd;
        end
        repeat (CPB) @(negedge clk);
        if (bus0.uart_txd === 1'b1) rx_q.push_back(rb);
      end
      prev = bus0.uart_txd;
    end
  end

  initial begin
    #(80_000 * 10);
    $display("FAIL watchdog: simulation exceeded 80000 cycles");
    $fatal(1, "watchdog");
  end

  task automatic push_byte(input byte_t b);
    fq.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rx_q.delete(); rd_cycles.delete(); done_cycles.delete();
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (fq.size() == 0 && bus0.fifo_empty === 1'b1 && bus0.tx_busy === 1'b0 && !sb_active) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (bus0.uart_txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b required 1", bus0.uart_txd); end
    checks++; if (bus0.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b required 0", bus0.fifo_rd_en); end
    checks++; if (bus0.tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", bus0.tx_busy); end
    checks++; if (bus0.byte_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", bus0.byte_done); end
    checks++; if (bus0.byte_cnt !== 32'd0) begin errors++; $display("FAIL reset_byte_cnt: got %0d required 0", bus0.byte_cnt); end
    checks++; if (bus0.line_cnt !== 32'd0) begin errors++; $display("FAIL reset_line_cnt: got %0d required 0", bus0.line_cnt); end
    mon_en = 1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    byte_t b;
    logic  txd_s[0:10*CPB+2];
    logic  done_s[0:10*CPB+2];
    bit    found, ok;
    b = 8'h41;
    do_reset();
    push_byte(b);
    found = 0;
    for (int i = 0; i < 6 && !found; i++) begin
      @(negedge clk);
      if (bus0.fifo_rd_en === 1'b1) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL single_rd_en: got no strobe required one within 6 cycles"); end
    for (int o = 1; o <= 10 * CPB + 1; o++) begin
      @(negedge clk);
      txd_s[o]  = bus0.uart_txd;
      done_s[o] = bus0.byte_done;
    end
    checks++; if (txd_s[1] !== 1'b1) begin errors++; $display("FAIL single_load_txd: got %b required 1", txd_s[1]); end
    checks++; if (txd_s[2] !== 1'b0 || txd_s[1+CPB] !== 1'b0) begin errors++; $display("FAIL single_start: got %b%b required 00", txd_s[2], txd_s[1+CPB]); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (txd_s[2+(k+1)*CPB] !== b[k] || txd_s[1+(k+2)*CPB] !== b[k]) begin
        errors++; $display("FAIL single_bit%0d: got %b%b required %b", k, txd_s[2+(k+1)*CPB], txd_s[1+(k+2)*CPB], b[k]);
      end
    end
    checks++; if (txd_s[2+9*CPB] !== 1'b1 || txd_s[1+10*CPB] !== 1'b1) begin errors++; $display("FAIL single_stop: got %b%b required 11", txd_s[2+9*CPB], txd_s[1+10*CPB]); end
    checks++; if (done_s[1+10*CPB] !== 1'b1 || done_s[10*CPB] !== 1'b0) begin errors++; $display("FAIL single_byte_done: got %b%b required 01", done_s[10*CPB], done_s[1+10*CPB]); end
    wait_drain(PITCH, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_drain: timed out"); end
    checks++; if (bus0.byte_cnt !== 32'd1 || bus0.line_cnt !== 32'd0) begin errors++; $display("FAIL single_counts: got %0d/%0d required 1/0", bus0.byte_cnt, bus0.line_cnt); end
    checks++; if (rx_q.size() != 1 || rx_q[0] !== b) begin errors++; $display("FAIL single_rx: got %0d bytes first %h required 1 byte 41", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00); end
  endtask

  task automatic test_full_line();
    byte_t line_b[57];
    string pre;
    bit    ok;
    int    bad;
    pre = "0001,";
    for (int i = 0; i < 5; i++) line_b[i] = pre[i];
    for (int i = 5; i < 54; i++) line_b[i] = byte_t'($urandom_range(48, 90));
    line_b[54] = 8'h2C; line_b[55] = 8'h0D; line_b[56] = 8'h0A;
    do_reset();
    for (int i = 0; i < 57; i++) push_byte(line_b[i]);
    wait_drain(58 * PITCH, ok);
    checks++; if (!ok) begin errors++; $display("FAIL line_drain: timed out"); end
    checks++; if (rd_cycles.size() != 57) begin errors++; $display("FAIL line_rd_count: got %0d required 57", rd_cycles.size()); end
    for (int i = 1; i < rd_cycles.size(); i++) begin
      checks++;
      if (rd_cycles[i] - rd_cycles[i-1] != PITCH) begin errors++; $display("FAIL line_pitch%0d: got %0d required %0d", i, rd_cycles[i] - rd_cycles[i-1], PITCH); end
    end
    bad = (rx_q.size() == 57) ? 0 : 1;
    for (int i = 0; i < 57 && i < rx_q.size(); i++) if (rx_q[i] !== line_b[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL line_string: got %0d bytes with %0d differences required 57 exact", rx_q.size(), bad); end
    checks++; if (bus0.byte_cnt !== 32'd57 || bus0.line_cnt !== 32'd1) begin errors++; $display("FAIL line_counts: got %0d/%0d required 57/1", bus0.byte_cnt, bus0.line_cnt); end
  endtask

  task automatic test_empty_stall();
    byte_t b[3];
    bit    ok, found;
    int    bad;
    for (int i = 0; i < 3; i++) b[i] = byte_t'($urandom_range(0, 255));
    do_reset();
    push_byte(b[0]); push_byte(b[1]);
    wait_drain(3 * PITCH, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_drain1: timed out"); end
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus0.fifo_rd_en !== 1'b0 || bus0.uart_txd !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_gap: got %0d active cycles required 0", bad); end
    push_byte(b[2]);
    found = 0;
    for (int i = 0; i < 4 && !found; i++) begin
      @(negedge clk);
      if (bus0.fifo_empty === 1'b0) found = 1;
    end
    checks++; if (!found || bus0.fifo_rd_en !== 1'b1) begin errors++; $display("FAIL stall_rd_en: got rd_en=%b required 1 when empty falls", bus0.fifo_rd_en); end
    @(negedge clk);
    checks++; if (bus0.uart_txd !== 1'b1) begin errors++; $display("FAIL stall_load_txd: got %b required 1", bus0.uart_txd); end
    @(negedge clk);
    checks++; if (bus0.uart_txd !== 1'b0) begin errors++; $display("FAIL stall_start: got %b required 0 two cycles after empty falls", bus0.uart_txd); end
    wait_drain(2 * PITCH, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_drain2: timed out"); end
    checks++;
    if (rx_q.size() != 3 || rx_q[0] !== b[0] || rx_q[1] !== b[1] || rx_q[2] !== b[2]) begin
      errors++; $display("FAIL stall_rx: got %0d bytes required %h %h %h", rx_q.size(), b[0], b[1], b[2]);
    end
  endtask

  task automatic test_reset_mid();
    byte_t b;
    bit    ok, found;
    b = byte_t'($urandom_range(0, 255));
    do_reset();
    push_byte(b);
    found = 0;
    for (int i = 0; i < 6 && !found; i++) begin
      @(negedge clk);
      if (bus0.fifo_rd_en === 1'b1) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL rmid_rd_en: got no strobe required one"); end
    repeat (2 + 5 * CPB + 3) @(negedge clk);
    checks++; if (bus0.uart_txd !== b[4]) begin errors++; $display("FAIL rmid_bit4: got %b required %b", bus0.uart_txd, b[4]); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus0.uart_txd !== 1'b1 || bus0.tx_busy !== 1'b0) begin errors++; $display("FAIL rmid_abort: got txd=%b busy=%b required 1 0", bus0.uart_txd, bus0.tx_busy); end
    checks++; if (bus0.byte_cnt !== 32'd0) begin errors++; $display("FAIL rmid_byte_cnt: got %0d required 0", bus0.byte_cnt); end
    repeat (10 * CPB) @(negedge clk);
    rx_q.delete();
    push_byte(8'h55);
    wait_drain(2 * PITCH, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_drain: timed out"); end
    checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'h55) begin errors++; $display("FAIL rmid_rx: got %0d bytes first %h required 55", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00); end
    checks++; if (bus0.byte_cnt !== 32'd1 || bus0.line_cnt !== 32'd0) begin errors++; $display("FAIL rmid_counts: got %0d/%0d required 1/0", bus0.byte_cnt, bus0.line_cnt); end
  endtask

  task automatic test_counter_wrap();
    bit ok;
    do_reset();
    for (int i = 0; i < 17; i++) push_byte(8'h0A);
    wait_drain(18 * PITCH, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_drain: timed out"); end
    checks++; if (bus1.byte_cnt !== 4'd1 || bus1.line_cnt !== 4'd1) begin errors++; $display("FAIL wrap_cnt4: got %0d/%0d required 1/1", bus1.byte_cnt, bus1.line_cnt); end
    checks++; if (bus0.byte_cnt !== 32'd17 || bus0.line_cnt !== 32'd17) begin errors++; $display("FAIL wrap_cnt32: got %0d/%0d required 17/17", bus0.byte_cnt, bus0.line_cnt); end
  endtask

  task automatic test_random();
    byte_t sent[$];
    int    lines, gap, bad;
    bit    ok;
    byte_t b;
    lines = 0;
    do_reset();
    for (int i = 0; i < 24; i++) begin
      b = ($urandom_range(0, 3) == 0) ? 8'h0A : byte_t'($urandom_range(0, 255));
      if (b == 8'h0A) lines++;
      sent.push_back(b);
      push_byte(b);
      gap = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 150);
      repeat (gap) @(negedge clk);
      @(negedge clk);
    end
    wait_drain(26 * PITCH, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rand_drain: timed out"); end
    bad = (rx_q.size() == sent.size()) ? 0 : 1;
    for (int i = 0; i < sent.size() && i < rx_q.size(); i++) if (rx_q[i] !== sent[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL rand_rx: got %0d bytes with %0d differences required %0d exact", rx_q.size(), bad, sent.size()); end
    checks++; if (bus0.byte_cnt !== 32'(sent.size()) || bus0.line_cnt !== 32'(lines)) begin errors++; $display("FAIL rand_counts: got %0d/%0d required %0d/%0d", bus0.byte_cnt, bus0.line_cnt, sent.size(), lines); end
    checks++; if (bus1.byte_cnt !== 4'(sent.size()) || bus1.line_cnt !== 4'(lines)) begin errors++; $display("FAIL rand_cnt4: got %0d/%0d required %0d/%0d", bus1.byte_cnt, bus1.line_cnt, sent.size() % 16, lines % 16); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mon_en = 0;
    rst    = 1'b1;
    test_reset();
    test_single();
    test_full_line();
    test_empty_stall();
    test_reset_mid();
    test_counter_wrap();
    test_random();
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
